// File: rtl/mem_arbiter_ctrl_pkg.sv
// Shared types and helpers for the RAM port arbiter: FSM states, access size
// codes and the size-to-byte-count mapping.
package mem_arbiter_ctrl_pkg;

    localparam int ADDR_W_DEF = 17;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IF_RD  = 2'd1,
        ST_MEM_RD = 2'd2,
        ST_MEM_WR = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Size code 3 is treated as a word access.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_ctrl.sv
// Arbitrates instruction fetch and load/store onto one byte-wide synchronous RAM,
// sequencing little-endian transfers one byte per cycle with one-cycle done pulses.
module mem_arbiter_ctrl
    import mem_arbiter_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    input  logic              if_flush_i,
    output logic [31:0]       if_data_o,
    output logic              if_done_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_size_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);

    state_t      r_state;
    logic [31:0] r_addr;
    logic [2:0]  r_cnt;
    logic [2:0]  r_n;
    logic [31:0] r_asm;
    logic [23:0] r_wdata;
    logic [7:0]  r_dout;
    logic        r_wr;
    logic [31:0] r_if_data;
    logic [31:0] r_mem_rdata;
    logic        r_if_done;
    logic        r_mem_done;

    logic [1:0]  w_lane;
    logic [2:0]  w_cnt_inc;
    logic [31:0] w_asm_next;
    logic        w_unused;

    // The byte arriving now was addressed two edges ago, so it lands one lane below r_cnt.
    assign w_lane    = r_cnt[1:0] - 2'd1;
    assign w_cnt_inc = r_cnt + 3'd1;
    assign w_unused  = ^r_addr[31:ADDR_W];

    always_comb begin
        // NOTE: default assignment first so no path leaves w_asm_next unassigned (no latch).
        w_asm_next = r_asm;
        w_asm_next[{w_lane, 3'b000} +: 8] = ram_din_i;
    end

    // NOTE: every register is updated with non-blocking assignments so all of them see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_n         <= '0;
            r_asm       <= '0;
            r_wdata     <= '0;
            r_dout      <= '0;
            r_wr        <= 1'b0;
            r_if_data   <= '0;
            r_mem_rdata <= '0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A requester still holding its request through its done cycle is not re-served.
                    if (!r_if_done && !r_mem_done) begin
                        if (mem_req_i) begin
                            r_addr <= mem_addr_i;
                            r_cnt  <= '0;
                            r_n    <= byte_count(mem_size_i);
                            r_asm  <= '0;
                            if (mem_we_i) begin
                                r_state <= ST_MEM_WR;
                                r_wr    <= 1'b1;
                                r_dout  <= mem_wdata_i[7:0];
                                r_wdata <= mem_wdata_i[31:8];
                            end else begin
                                r_state <= ST_MEM_RD;
                            end
                        end else if (if_req_i && !if_flush_i) begin
                            r_state <= ST_IF_RD;
                            r_addr  <= if_addr_i;
                            r_cnt   <= '0;
                            r_n     <= byte_count(SZ_WORD);
                            r_asm   <= '0;
                        end
                    end
                end
                ST_IF_RD, ST_MEM_RD: begin
                    if (r_state == ST_IF_RD && if_flush_i) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == r_n) begin
                        r_state <= ST_IDLE;
                        if (r_state == ST_IF_RD) begin
                            r_if_data <= w_asm_next;
                            r_if_done <= 1'b1;
                        end else begin
                            r_mem_rdata <= w_asm_next;
                            r_mem_done  <= 1'b1;
                        end
                    end else begin
                        if (r_cnt != 3'd0) begin
                            r_asm <= w_asm_next;
                        end
                        if (w_cnt_inc < r_n) begin
                            r_addr <= r_addr + 32'd1;
                        end
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_MEM_WR: begin
                    if (w_cnt_inc == r_n) begin
                        r_state    <= ST_IDLE;
                        r_wr       <= 1'b0;
                        r_dout     <= '0;
                        r_mem_done <= 1'b1;
                    end else begin
                        r_addr  <= r_addr + 32'd1;
                        r_dout  <= r_wdata[7:0];
                        r_wdata <= {8'h00, r_wdata[23:8]};
                        r_cnt   <= w_cnt_inc;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign if_data_o   = r_if_data;
    assign if_done_o   = r_if_done;
    assign mem_rdata_o = r_mem_rdata;
    assign mem_done_o  = r_mem_done;
    assign busy_o      = (r_state != ST_IDLE);
    assign ram_a_o     = r_addr[ADDR_W-1:0];
    assign ram_wr_o    = r_wr;
    assign ram_dout_o  = r_dout;

endmodule
